// File: rtl/mem_access_unit.sv
// Byte/halfword/word load-store front end for a word-only data memory.
// Narrow stores use read-modify-write; loads are sign- or zero-extended.
module mem_access_unit #(
    parameter int unsigned ADDR_W = 6
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              Req,
    input  logic              Store,
    input  logic [1:0]        Size,
    input  logic              Signed,
    input  logic [31:0]       Addr,
    input  logic [31:0]       WData,
    output logic              Busy,
    output logic              Done,
    output logic              Err,
    output logic [31:0]       RData,
    output logic [ADDR_W-1:0] MemA,
    output logic              MemWE,
    output logic [31:0]       MemWD,
    input  logic [31:0]       MemRD
);

    localparam int unsigned DATA_W = 32;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t state;
    state_t next_state;

    logic [1:0]        off_q;
    logic [1:0]        size_q;
    logic              store_q;
    logic              signed_q;
    logic [DATA_W-1:0] wdata_q;

    logic              bad_c;
    logic [DATA_W-1:0] load_c;
    logic [DATA_W-1:0] merge_c;

    // Request legality: reserved size, misalignment, or beyond the memory's byte range.
    always_comb begin
        bad_c = 1'b0;
        if (Size == SZ_RSVD)                      bad_c = 1'b1;
        if ((Size == SZ_HALF) && Addr[0])         bad_c = 1'b1;
        if ((Size == SZ_WORD) && (|Addr[1:0]))    bad_c = 1'b1;
        if (|Addr[31:ADDR_W+2])                   bad_c = 1'b1;
    end

    // Load formatting and store lane merge, both operating on the word read this cycle.
    always_comb begin
        logic [DATA_W-1:0] shifted;
        logic [DATA_W-1:0] mask;
        logic [DATA_W-1:0] lane;
        logic [4:0]        shamt;

        shamt   = {off_q, 3'b000};
        shifted = MemRD >> shamt;
        load_c  = MemRD;
        mask    = '0;
        lane    = '0;
        merge_c = wdata_q;

        case (size_q)
            SZ_BYTE: load_c = signed_q ? {{24{shifted[7]}}, shifted[7:0]}
                                       : {24'h000000, shifted[7:0]};
            SZ_HALF: load_c = signed_q ? {{16{shifted[15]}}, shifted[15:0]}
                                       : {16'h0000, shifted[15:0]};
            default: load_c = MemRD;
        endcase

        case (size_q)
            SZ_BYTE: begin
                mask    = DATA_W'(32'h0000_00FF) << shamt;
                lane    = DATA_W'(wdata_q[7:0]) << shamt;
                merge_c = (MemRD & ~mask) | (lane & mask);
            end
            SZ_HALF: begin
                mask    = DATA_W'(32'h0000_FFFF) << shamt;
                lane    = DATA_W'(wdata_q[15:0]) << shamt;
                merge_c = (MemRD & ~mask) | (lane & mask);
            end
            default: merge_c = wdata_q;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state <= S_IDLE;
        else        state <= next_state;
    end

    // Next-state logic; Req is only looked at in IDLE.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (Req) next_state = bad_c ? S_ERR : S_READ;
            S_READ:  next_state = store_q ? S_WRITE : S_DONE;
            S_WRITE: next_state = S_DONE;
            S_DONE:  next_state = S_IDLE;
            S_ERR:   next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Status and memory strobes are registered decodes of the next state only.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            Busy  <= 1'b0;
            Done  <= 1'b0;
            Err   <= 1'b0;
            MemWE <= 1'b0;
        end else begin
            Busy  <= (next_state != S_IDLE);
            Done  <= (next_state == S_DONE) || (next_state == S_ERR);
            Err   <= (next_state == S_ERR);
            MemWE <= (next_state == S_WRITE);
        end
    end

    // Request capture and data path registers.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            MemA     <= '0;
            off_q    <= '0;
            size_q   <= '0;
            store_q  <= 1'b0;
            signed_q <= 1'b0;
            wdata_q  <= '0;
            RData    <= '0;
            MemWD    <= '0;
        end else begin
            if ((state == S_IDLE) && Req) begin
                MemA     <= Addr[ADDR_W+1:2];
                off_q    <= Addr[1:0];
                size_q   <= Size;
                store_q  <= Store;
                signed_q <= Signed;
                wdata_q  <= WData;
            end
            if (state == S_READ) begin
                if (store_q) MemWD <= merge_c;
                else         RData <= load_c;
            end
        end
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sits directly upstream of the 64-word DataMemory, between the processor load/store path and the memory.
- Converts byte-addressed byte, halfword and word load/store requests into word accesses on the memory's word-only port.
- Stores narrower than a word use a read-modify-write sequence; loads are sign- or zero-extended.
- Misaligned and out-of-range accesses are rejected without touching memory.

Parameters:
- ADDR_W, 6, word-address width driven to DataMemory; the valid byte range is 0 to 2^(ADDR_W+2)-1.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- Req  in  1  request strobe; sampled only in IDLE.
- Store  in  1  1 = store, 0 = load.
- Size  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
- Signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- Addr  in  32  byte address.
- WData  in  32  store data; the low byte/half is used for narrow stores.
- Busy  out  1  high in every state except IDLE.
- Done  out  1  one-cycle completion pulse.
- Err  out  1  one-cycle pulse coincident with Done on a rejected access.
- RData  out  32  load result; held until the next completed load.
- MemA  out  ADDR_W  word address to DataMemory.
- MemWE  out  1  write enable to DataMemory.
- MemWD  out  32  write data to DataMemory.
- MemRD  in  32  combinational read data from DataMemory.

Behaviour:
- Reset: asynchronous and active-low. State goes to IDLE; Busy, Done, Err, MemWE = 0; RData, MemA, MemWD = 0.
- FSM states: IDLE, READ, WRITE, DONE, ERR.
- Byte order: little-endian within a word. Byte offset 0 = bits [7:0]; offset 3 = bits [31:24]; halfword offset 2 = bits [31:16].
- IDLE, Req=1 at a rising edge: latch Addr, Size, Store, Signed and WData.
  - Go to ERR if any of: Size=11; halfword with Addr[0]=1; word with Addr[1:0]≠0; Addr[31:ADDR_W+2]≠0.
  - Otherwise go to READ.
- READ: MemA = latched Addr[ADDR_W+1:2]. At the edge, capture MemRD into an internal word register.
  - Load: RData <= formatted result; go to DONE.
  - Store: go to WRITE.
- WRITE: MemWE=1 for exactly this one cycle.
  - MemWD = captured word with only the addressed byte/half lane replaced by the low WData bits.
  - A word store replaces all 32 bits.
  - Go to DONE.
- DONE: Done=1 for one cycle, then IDLE.
- ERR: Done=1 and Err=1 for one cycle, then IDLE. MemWE is never asserted on this path.
- Latency (cycles after the Req-sampling edge until the Done cycle):
  - load: 2 (READ, then DONE);
  - store: 3 (READ, WRITE, then DONE);
  - error: 1.
- Back-to-back: a Req sampled in the DONE cycle is ignored. The earliest next accept is the first edge in IDLE.
- Req while Busy=1 is ignored: no queueing, and the latched request is unaffected by input changes.
- MemWE is decoded from state only, never from inputs, so it is glitch-free with respect to Req and WData.
- Reset mid-operation: the state machine returns to IDLE immediately and MemWE drops asynchronously.
  - A store reset in WRITE before the rising edge leaves memory unchanged.
  - No Done pulse is produced for the aborted request.
- RData is not modified by stores or errors.

Test Plan:
- Preload mem[4]=0xDEADBEEF; word load at Addr=0x10 → Done 2 cycles after Req, RData=0xDEADBEEF, Err=0, MemWE stays 0.
- Byte loads at Addr=0x13 → Signed=1 gives RData=0xFFFFFFDE; Signed=0 gives RData=0x000000DE. Halfword signed load at 0x10 → 0xFFFFBEEF.
- Halfword store, WData=0x00001234, Addr=0x12 → MemWE high exactly one cycle, mem[4]=0x1234BEEF, Done 3 cycles after Req. A following byte store of 0xAA to 0x10 gives 0x1234BEAA.
- Rejected accesses: word at 0x11, half at 0x13, Size=11, and Addr=0x100 → each gives Done=Err=1 one cycle after Req, MemWE never high, mem unchanged.
- Req held high continuously with changing Addr → each request accepted only from IDLE. Latched values are used and completions are spaced per the latencies above.
- Store to 0x10 with RESET asserted low during the WRITE cycle before the edge → MemWE falls immediately, mem[4] is unchanged, no Done, and the block is in IDLE with all outputs at reset values.
